// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: pcsrc encodings, NOP word, IF state.
package pipe_pkg;

  localparam logic [1:0]  PC_SEQ   = 2'b00;
  localparam logic [1:0]  PC_BR    = 2'b01;
  localparam logic [1:0]  PC_JR    = 2'b10;
  localparam logic [1:0]  PC_J     = 2'b11;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    WAIT = 1'b0,
    FULL = 1'b1
  } if_state_e;

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC select: pcsrc target mux, then redirect > pending target > pc+4.
module pipe_npc_mux
  import pipe_pkg::*;
(
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic [31:0] pc,
  input  logic [31:0] tgt,
  input  logic        tgt_vld,
  input  logic        redir,
  output logic [31:0] target,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc
);

  // Redirect target and prioritised next PC
  always_comb begin
    pc_plus4 = pc + 32'd4;
    case (pcsrc)
      PC_BR:   target = bpc;
      PC_JR:   target = rpc;
      PC_J:    target = jpc;
      default: target = pc_plus4;
    endcase
    if (redir)        npc = target;
    else if (tgt_vld) npc = tgt;
    else              npc = pc_plus4;
  end

endmodule

// File: rtl/pipe_ifetch.sv
// IF stage: PC, variable-latency instruction fetch, IF/ID register, delayed-branch redirect.
module pipe_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        nostall,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        ivalid
);

  import pipe_pkg::*;

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic        ivalid_q, ivalid_d;
  logic [31:0] tgt_q, tgt_d;
  logic        tgt_vld_q, tgt_vld_d;
  logic [31:0] buf_q, buf_d;

  logic        ack_v;
  logic        xfer;
  logic        redir;
  logic [31:0] fetched;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] npc;

  assign imem_req  = (state_q == WAIT) & ~clr;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign dpc4      = dpc4_q;
  assign ivalid    = ivalid_q;

  // An ack without a live request is ignored
  assign ack_v   = imem_ack & imem_req;
  assign xfer    = nostall & (((state_q == WAIT) & ack_v) | (state_q == FULL));
  assign redir   = nostall & ivalid_q & (pcsrc != PC_SEQ);
  assign fetched = (state_q == FULL) ? buf_q : imem_rdata;

  pipe_npc_mux u_npc (
    .pcsrc    (pcsrc),
    .bpc      (bpc),
    .rpc      (rpc),
    .jpc      (jpc),
    .pc       (pc_q),
    .tgt      (tgt_q),
    .tgt_vld  (tgt_vld_q),
    .redir    (redir),
    .target   (target),
    .pc_plus4 (pc_plus4),
    .npc      (npc)
  );

  // Next-state: fetch FSM, IF/ID load/bubble/hold, PC and pending-target update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    dpc4_d    = dpc4_q;
    ivalid_d  = ivalid_q;
    tgt_d     = tgt_q;
    tgt_vld_d = tgt_vld_q;
    buf_d     = buf_q;

    case (state_q)
      WAIT: if (ack_v && !nostall) begin
        state_d = FULL;
        buf_d   = imem_rdata;
      end
      FULL: if (nostall) state_d = WAIT;
      default: state_d = WAIT;
    endcase

    if (xfer) begin
      inst_d    = fetched;
      dpc4_d    = pc_plus4;
      ivalid_d  = 1'b1;
      pc_d      = npc;
      tgt_vld_d = 1'b0;
    end else if (nostall) begin
      inst_d   = NOP_INST;
      ivalid_d = 1'b0;
      // Delay slot still in flight: park the target until it is delivered
      if (redir) begin
        tgt_d     = target;
        tgt_vld_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= WAIT;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      dpc4_q    <= '0;
      ivalid_q  <= 1'b0;
      tgt_q     <= '0;
      tgt_vld_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      dpc4_q    <= dpc4_d;
      ivalid_q  <= ivalid_d;
      tgt_q     <= tgt_d;
      tgt_vld_q <= tgt_vld_d;
      buf_q     <= buf_d;
    end
  end

endmodule

// File: doc/pipe_ifetch.md
Name: pipe_ifetch

Overview:
- IF stage of the 5-stage pipeline, directly upstream of the ID stage control unit.
- Holds the PC and fetches from an instruction memory with a variable-latency req/ack handshake.
- Drives the IF/ID register (inst, dpc4, ivalid) and applies ID-stage redirects (pcsrc) with MIPS delayed-branch semantics.
- Obeys the ID stall (nostall); inserts bubbles when a fetch is still outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word written into IF/ID on a bubble (sll $0,$0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
clr  in  1  synchronous active-high reset
nostall  in  1  from ID control unit; 1 = IF/ID may load, ID instruction advances
pcsrc  in  2  from ID control unit: 00 pc+4, 01 branch bpc, 10 jr rpc, 11 jump jpc
bpc  in  32  branch target computed in ID
rpc  in  32  jr target (forwarded rs value)
jpc  in  32  jump/jal target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  read data valid this cycle; only meaningful while imem_req=1
imem_rdata  in  32  instruction word
pc  out  32  current fetch PC
inst  out  32  IF/ID instruction register to ID
dpc4  out  32  IF/ID pc+4 of inst
ivalid  out  1  inst holds a real instruction (0 = bubble)

Behaviour:
- Reset (clr=1 at edge): pc=RESET_PC, state=WAIT, inst=NOP_INST, dpc4=0, ivalid=0, tgt=0, tgt_vld=0, buf=0. imem_req=0 while clr is high.
- imem_req = (state==WAIT) & ~clr. imem_addr = pc, held stable until ack.
- Slave treats deassertion of req (reset) as an abort. An ack in a cycle with req=0 is ignored.
- States:
  - WAIT: request outstanding.
    - ack & nostall -> transfer imem_rdata to IF/ID, stay WAIT.
    - ack & ~nostall -> capture rdata into buf, go FULL.
    - no ack: stay WAIT.
  - FULL: req=0, buf holds the next instruction.
    - nostall -> transfer buf to IF/ID, go WAIT.
    - otherwise hold.
- xfer = nostall & ((WAIT & ack) | FULL). On xfer: inst<=fetched word, dpc4<=pc+4, ivalid<=1.
- nostall & ~xfer: inst<=NOP_INST, ivalid<=0, dpc4 unchanged (bubble).
- nostall=0: IF/ID (inst, dpc4, ivalid) holds.
- Redirect: redir = nostall & ivalid & (pcsrc!=00). Target = bpc / rpc / jpc per pcsrc.
- Delay slot: the instruction at the current pc is the delay slot and is always delivered, never squashed.
- pc update only on xfer, with priority:
  - redir -> target
  - else tgt_vld -> tgt, clear tgt_vld
  - else pc+4
- redir & ~xfer (delay slot still in flight): tgt<=target, tgt_vld<=1. pc unchanged.
- redir while tgt_vld=1 cannot occur, since ID holds a bubble until the delay slot arrives. Assertion in bench.
- pcsrc/targets are sampled only when ivalid=1; bubble decodes yield pcsrc=00.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Throughput: zero-wait memory (ack in the req cycle) plus nostall=1 gives 1 instruction/cycle. Each extra wait cycle inserts 1 bubble.
- One outstanding fetch max; no prefetch beyond buf.

Decomposition:
- Shared package pipe_pkg:
  - pcsrc encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_JR=2'b10, PC_J=2'b11
  - NOP_INST constant
  - IF state enum {WAIT, FULL}
- Sub-module pipe_npc_mux: 4:1 pcsrc target select plus tgt_vld/pc+4 priority, purely combinational.

Test Plan:
- Reset then zero-wait memory (ack=req), nostall=1 -> addr 0,4,8,C on consecutive cycles; ivalid=1 from second cycle; dpc4=4,8,C.
- ack delayed 2 cycles per fetch -> each fetch produces 2 bubbles (inst=0, ivalid=0) then the instruction; pc advances only on ack.
- nostall=0 for 3 cycles while ack arrives at pc=8 -> state FULL, req=0, IF/ID frozen. When nostall=1, the word for 8 enters IF/ID and req resumes at C.
- beq at 0x10 in ID, pcsrc=01, bpc=0x40, delay slot 0x14 acked same cycle -> next fetch addr 0x40; IF/ID gets 0x14's word.
- jr at 0x20, pcsrc=10, rpc=0x100, delay-slot fetch 0x24 still waiting -> tgt_vld=1, ID gets a bubble. On 0x24's ack the next addr is 0x100 and tgt_vld clears.
- clr asserted while req outstanding at pc=0x30 -> next cycle req=0, ivalid=0, pc=RESET_PC. A late ack during clr is ignored; after clr drops, the first fetch is at RESET_PC.
